// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multiply/divide unit: FSM encoding, operand width, iteration counts.
package mult_div_pkg;
  localparam int WIDTH     = 32;
  localparam int MULT_ITER = 16;
  localparam int DIV_ITER  = 32;
  localparam int ACC_W     = 2 * WIDTH + 2;
  localparam int CNT_W     = $clog2(DIV_ITER);

  typedef enum logic [1:0] { IDLE, MULT, DIV, FIN } state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
endpackage

// File: rtl/booth_step.sv
// One radix-4 Booth iteration: add the recoded partial product to the accumulator top, then shift right by 2.
module booth_step
  import mult_div_pkg::*;
(
  input  logic [2:0]       digit,
  input  logic [WIDTH-1:0] mcand,
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out
);
  localparam int SUM_W = WIDTH + 3;

  logic [SUM_W-1:0]       m_ext;
  logic [SUM_W-1:0]       part;
  logic [SUM_W-1:0]       sum;
  logic [SUM_W+WIDTH:0]   wide;

  always_comb begin
    m_ext = {{3{mcand[WIDTH-1]}}, mcand};
    case (digit)
      3'b001, 3'b010: part = m_ext;
      3'b011:         part = {m_ext[SUM_W-2:0], 1'b0};
      3'b100:         part = -{m_ext[SUM_W-2:0], 1'b0};
      3'b101, 3'b110: part = -m_ext;
      default:        part = '0;
    endcase
    // Two guard bits keep +/-2M from overflowing the 33-bit upper half before the shift.
    sum     = {{2{acc_in[ACC_W-1]}}, acc_in[ACC_W-1:WIDTH+1]} + part;
    wide    = {sum, acc_in[WIDTH:0]};
    acc_out = wide[SUM_W+WIDTH:2];
  end
endmodule

// File: rtl/mult_div_ctrl.sv
// Sequential signed multiply (radix-4 Booth) / divide (non-restoring) unit with HI/LO result registers.
// The divide path exists only when MULT_DIV_CTRL_DIV_EN is defined; otherwise start_div is ignored.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mult_div_pkg::*;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc, acc_mult;
  logic [WIDTH-1:0] operand;
  logic             accept_mult, accept_div, last_iter;

  assign accept_mult = (state == IDLE) && start_mult;
  assign last_iter   = (count == '0);

  booth_step u_booth_step (
    .digit   (acc[2:0]),
    .mcand   (operand),
    .acc_in  (acc),
    .acc_out (acc_mult)
  );

`ifdef MULT_DIV_CTRL_DIV_EN
  logic             neg_quo, neg_rem, dbz;
  logic [WIDTH+1:0] rem_shift, rem_new;
  logic [WIDTH-1:0] quo_new, rem_fix, quo_res, rem_res;

  assign accept_div  = (state == IDLE) && start_div && !start_mult;
  assign div_by_zero = dbz;

  // Partial remainder lives in acc[ACC_W-1:WIDTH]; dividend bits shift out of acc[WIDTH-1:0] as quotient bits enter.
  always_comb begin
    rem_shift = acc[ACC_W-2:WIDTH-1];
    rem_new   = acc[ACC_W-1] ? rem_shift + {2'b00, operand} : rem_shift - {2'b00, operand};
    quo_new   = {acc[WIDTH-2:0], ~rem_new[WIDTH+1]};
    rem_fix   = rem_new[WIDTH-1:0] + (rem_new[WIDTH+1] ? operand : '0);
    quo_res   = neg_quo ? -quo_new : quo_new;
    rem_res   = neg_rem ? -rem_fix : rem_fix;
  end
`else
  logic unused_start_div;
  assign accept_div       = 1'b0;
  assign div_by_zero      = 1'b0;
  assign unused_start_div = start_div;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_mult)     state_next = MULT;
        else if (accept_div) state_next = (b == '0) ? FIN : DIV;
      end
      MULT, DIV: if (last_iter) state_next = FIN;
      FIN:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MULT) || (state == DIV);
    done = (state == FIN);
  end

  // Results are written on the final iteration edge so hi/lo are already valid in the FIN (done) cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULT_DIV_CTRL_DIV_EN
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      dbz     <= 1'b0;
`endif
    end else begin
      if (accept_mult) begin
        count   <= CNT_W'(MULT_ITER - 1);
        acc     <= {{(ACC_W-WIDTH-1){1'b0}}, b, 1'b0};
        operand <= a;
`ifdef MULT_DIV_CTRL_DIV_EN
        dbz     <= 1'b0;
`endif
      end
`ifdef MULT_DIV_CTRL_DIV_EN
      else if (accept_div) begin
        count   <= CNT_W'(DIV_ITER - 1);
        acc     <= {{(ACC_W-WIDTH){1'b0}}, magnitude(a)};
        operand <= magnitude(b);
        neg_quo <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_rem <= a[WIDTH-1];
        dbz     <= (b == '0);
      end else if (state == DIV) begin
        acc <= {rem_new, quo_new};
        if (!last_iter) count <= count - 1'b1;
        else begin
          hi <= rem_res;
          lo <= quo_res;
        end
      end
`endif
      else if (state == MULT) begin
        acc <= acc_mult;
        if (!last_iter) count <= count - 1'b1;
        else begin
          hi <= acc_mult[ACC_W-2:WIDTH+1];
          lo <= acc_mult[WIDTH:1];
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized self-checking bench for mult_div_ctrl against a plain-arithmetic reference model.
// Divide scenarios run when MULT_DIV_CTRL_DIV_EN is defined; otherwise start_div must be ignored.
`timescale 1ns/1ps
module tb_mult_div_ctrl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dbz = 1'b0;

`ifdef MULT_DIV_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: updates expected hi/lo/flag and returns expected done cycle (0 = request ignored).
  task automatic model(input bit is_mult, input bit is_div, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    longint p, q, r;
    lat = 0;
    if (is_mult) begin
      p = longint'($signed(x)) * longint'($signed(y));
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_dbz = 1'b0;
      lat = 17;
    end else if (is_div && DIV_EN) begin
      if (y == 32'h0) begin
        exp_dbz = 1'b1;
        lat = 1;
      end else begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        exp_lo = q[31:0];
        exp_hi = r[31:0];
        exp_dbz = 1'b0;
        lat = 33;
      end
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] t;
    case ($urandom_range(0, 6))
      0: t = 32'h8000_0000;
      1: t = 32'hFFFF_FFFF;
      2: t = 32'h0;
      3: t = 32'($urandom_range(0, 20));
      4: begin t = 32'($urandom_range(1, 20)); t = -t; end
      default: t = $urandom;
    endcase
    return t;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the cycle after done.
  task automatic run_op(input string tag, input bit m, input bit d, input logic [31:0] x,
                        input logic [31:0] y, input int poke);
    int          elat, lat, busy_err, hold_err;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi;
    old_lo = exp_lo;
    model(m, d, x, y, elat);
    start_mult = m;
    start_div = d;
    a = x;
    b = y;
    @(negedge clock);
    lat = 1;
    busy_err = 0;
    hold_err = 0;
    while (lat <= 40) begin
      start_mult = 1'b0;
      start_div = 1'b0;
      a = $urandom;
      b = $urandom;
      if (done === 1'b1) break;
      if (busy !== (elat != 0)) busy_err++;
      if (hi !== old_hi || lo !== old_lo) hold_err++;
      if (lat == poke) begin
        start_mult = 1'b1;
        start_div = 1'b1;
      end
      @(negedge clock);
      lat++;
    end
    start_mult = 1'b0;
    start_div = 1'b0;
    if (lat <= 40 && busy !== 1'b0) busy_err++;
    check({tag, "/done_cycle"}, 64'(lat), (elat == 0) ? 64'd41 : 64'(elat));
    check({tag, "/busy"}, 64'(busy_err), 64'd0);
    check({tag, "/hold"}, 64'(hold_err), 64'd0);
    check({tag, "/hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "/lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "/dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    $display("[TB] %s a=%h b=%h done_cycle=%0d hi=%h lo=%h dbz=%b", tag, x, y, lat, hi, lo, div_by_zero);
    @(negedge clock);
    check({tag, "/after"}, 64'({busy, done}), 64'd0);
  endtask

  task automatic reset_mid(input bit use_div);
    int bad;
    bad = 0;
    start_mult = !use_div;
    start_div = use_div;
    a = $urandom;
    b = $urandom | 32'h1;
    @(negedge clock);
    start_mult = 1'b0;
    start_div = 1'b0;
    repeat (9) @(negedge clock);
    check("rst_mid/busy_before", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid/ctl", 64'({busy, done, div_by_zero}), 64'd0);
    check("rst_mid/hi", 64'(hi), 64'd0);
    check("rst_mid/lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    exp_dbz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      if (hi !== 32'h0 || lo !== 32'h0) bad++;
    end
    check("rst_mid/aborted", 64'(bad), 64'd0);
    $display("[TB] reset during %s at cycle 10, quiet cycles checked=40", use_div ? "divide" : "multiply");
  endtask

  initial begin
    logic [31:0] x, y;
    bit          do_div;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset/ctl", 64'({busy, done, div_by_zero}), 64'd0);
    check("reset/hi", 64'(hi), 64'd0);
    check("reset/lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset/idle", 64'({busy, done}), 64'd0);

    run_op("mult_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    check("mult_7x-3/hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_7x-3/lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op("mult_min_sq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    check("mult_min_sq/hi_const", 64'(hi), 64'h4000_0000);
    run_op("both_start", 1'b1, 1'b1, 32'd12345, 32'hFFFF_FD5A, 5);
`ifdef MULT_DIV_CTRL_DIV_EN
    run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0, 0);
    run_op("mult_clr", 1'b1, 1'b0, $urandom, $urandom, 0);
    run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_poke", 1'b0, 1'b1, $urandom, $urandom | 32'h1, 10);
`else
    run_op("div_ignored", 1'b0, 1'b1, 32'd5, 32'd3, 0);
    run_op("div_ignored2", 1'b0, 1'b1, 32'd9, 32'd0, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      x = pick();
      y = pick();
      do_div = DIV_EN && ($urandom_range(0, 1) == 1);
      run_op($sformatf("rnd%0d", i), !do_div, do_div, x, y, (i % 3 == 0) ? $urandom_range(2, 15) : 0);
    end

    reset_mid(DIV_EN);
    run_op("post_rst", 1'b1, 1'b0, $urandom, $urandom, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
